// File: rtl/meter_pkg.sv
// Shared types, defaults and helpers for the parking-meter engine.
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_LOW  = 2'd1,
        MODE_HIGH = 2'd2
    } blink_mode_t;

    localparam int unsigned DEF_DIGITS     = 4;
    localparam int unsigned DEF_MAX_VALUE  = 9999;
    localparam int unsigned DEF_ADD_U      = 10;
    localparam int unsigned DEF_ADD_L      = 180;
    localparam int unsigned DEF_ADD_R      = 200;
    localparam int unsigned DEF_ADD_D      = 550;
    localparam int unsigned DEF_PRESET_A   = 10;
    localparam int unsigned DEF_PRESET_B   = 205;
    localparam int unsigned DEF_LOW_THRESH = 200;

    function automatic int unsigned bin_w(input int unsigned max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, restartable at any time,
// bcd holds the last completed result.
module bin2bcd_seq
    import meter_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned WORK_W = BCD_W + BIN_W;

    conv_state_t        state, state_n;
    logic [BIN_W-1:0]   sh, sh_n;
    logic [BCD_W-1:0]   wk, wk_n, adj_c, bcd_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WORK_W-1:0]  cat_c;
    logic               done_n;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            sh    <= '0;
            wk    <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            wk    <= wk_n;
            cnt   <= cnt_n;
            bcd   <= bcd_n;
            done  <= done_n;
        end
    end

    // A start in any state reloads the shifter, so a stale conversion never lands in bcd.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        wk_n    = wk;
        cnt_n   = cnt;
        bcd_n   = bcd;
        done_n  = 1'b0;

        adj_c = wk;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (wk[4*i +: 4] > 4'd4) begin
                adj_c[4*i +: 4] = wk[4*i +: 4] + 4'd3;
            end
        end
        cat_c = {adj_c, sh} << 1;

        if (start) begin
            state_n = SHIFT;
            sh_n    = bin;
            wk_n    = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                SHIFT: begin
                    wk_n  = cat_c[WORK_W-1:BIN_W];
                    sh_n  = cat_c[BIN_W-1:0];
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    bcd_n   = wk;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/parking_meter_core.sv
// Parking-meter engine: saturating remaining-time count with button adds, preset loads and
// 1 Hz decrement, plus BCD display feed, blink strobe and expiry LED.
module parking_meter_core
    import meter_pkg::*;
#(
    parameter int unsigned DIGITS     = DEF_DIGITS,
    parameter int unsigned MAX_VALUE  = DEF_MAX_VALUE,
    parameter int unsigned ADD_U      = DEF_ADD_U,
    parameter int unsigned ADD_L      = DEF_ADD_L,
    parameter int unsigned ADD_R      = DEF_ADD_R,
    parameter int unsigned ADD_D      = DEF_ADD_D,
    parameter int unsigned PRESET_A   = DEF_PRESET_A,
    parameter int unsigned PRESET_B   = DEF_PRESET_B,
    parameter int unsigned LOW_THRESH = DEF_LOW_THRESH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  TICK_1HZ,
    input  logic                  TICK_2HZ,
    input  logic                  BTN_U,
    input  logic                  BTN_L,
    input  logic                  BTN_R,
    input  logic                  BTN_D,
    input  logic                  LOAD_A,
    input  logic                  LOAD_B,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  BLANK,
    output logic                  LED
);

    localparam int unsigned BIN_W = bin_w(MAX_VALUE);
    localparam int unsigned SUM_W = BIN_W + 1;

    logic [BIN_W-1:0] count, count_nxt_c, sat_c;
    logic [SUM_W-1:0] add_c, sum_c;
    logic             load_c, ph, ph_nxt_c, led_nxt_c, init_q, start_c;
    blink_mode_t      mode_cur_c, mode_nxt_c;
    logic             conv_busy_unused, conv_done_unused;

    function automatic blink_mode_t mode_of(input logic [BIN_W-1:0] c);
        if (c == '0) begin
            return MODE_ZERO;
        end
        if (32'(c) < LOW_THRESH) begin
            return MODE_LOW;
        end
        return MODE_HIGH;
    endfunction

    // Count datapath: load > highest button > tick; blink mode follows the next count.
    always_comb begin
        load_c      = LOAD_A | LOAD_B;
        add_c       = '0;
        count_nxt_c = count;
        ph_nxt_c    = ph;

        if (BTN_U) begin
            add_c = SUM_W'(ADD_U);
        end else if (BTN_L) begin
            add_c = SUM_W'(ADD_L);
        end else if (BTN_R) begin
            add_c = SUM_W'(ADD_R);
        end else if (BTN_D) begin
            add_c = SUM_W'(ADD_D);
        end

        sum_c = SUM_W'(count) + add_c;
        sat_c = (sum_c > SUM_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : sum_c[BIN_W-1:0];

        if (LOAD_A) begin
            count_nxt_c = BIN_W'(PRESET_A);
        end else if (LOAD_B) begin
            count_nxt_c = BIN_W'(PRESET_B);
        end else if (TICK_1HZ && (sat_c != '0)) begin
            count_nxt_c = sat_c - BIN_W'(1);
        end else begin
            count_nxt_c = sat_c;
        end

        mode_cur_c = mode_of(count);
        mode_nxt_c = mode_of(count_nxt_c);

        // Ticks arriving with a load are dropped for the blink phase as well as the count.
        if ((mode_nxt_c != mode_cur_c) || (mode_nxt_c == MODE_HIGH)) begin
            ph_nxt_c = 1'b0;
        end else if (!load_c) begin
            ph_nxt_c = ph ^ ((mode_nxt_c == MODE_ZERO) ? TICK_2HZ : TICK_1HZ);
        end

        led_nxt_c = (count_nxt_c == '0);
        start_c   = init_q | (count_nxt_c != count);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count  <= '0;
            ph     <= 1'b0;
            LED    <= 1'b1;
            init_q <= 1'b1;
        end else begin
            count  <= count_nxt_c;
            ph     <= ph_nxt_c;
            LED    <= led_nxt_c;
            init_q <= 1'b0;
        end
    end

    assign BLANK = ph;

    // Converter loads count_nxt_c on the same edge the count register takes it.
    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .CLK   (CLK),
        .RESET (RESET),
        .start (start_c),
        .bin   (count_nxt_c),
        .busy  (conv_busy_unused),
        .done  (conv_done_unused),
        .bcd   (BCD)
    );

endmodule

// File: tb/tb_parking_meter_core.sv
// Self-checking bench for parking_meter_core: vector table, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_parking_meter_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        TICK_1HZ = 1'b0;
    logic        TICK_2HZ = 1'b0;
    logic        BTN_U = 1'b0;
    logic        BTN_L = 1'b0;
    logic        BTN_R = 1'b0;
    logic        BTN_D = 1'b0;
    logic        LOAD_A = 1'b0;
    logic        LOAD_B = 1'b0;
    logic [15:0] BCD;
    logic        BLANK;
    logic        LED;

    parking_meter_core #(
        .DIGITS     (4),
        .MAX_VALUE  (9999),
        .ADD_U      (10),
        .ADD_L      (180),
        .ADD_R      (200),
        .ADD_D      (550),
        .PRESET_A   (10),
        .PRESET_B   (205),
        .LOW_THRESH (200)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .TICK_1HZ (TICK_1HZ),
        .TICK_2HZ (TICK_2HZ),
        .BTN_U    (BTN_U),
        .BTN_L    (BTN_L),
        .BTN_R    (BTN_R),
        .BTN_D    (BTN_D),
        .LOAD_A   (LOAD_A),
        .LOAD_B   (LOAD_B),
        .BCD      (BCD),
        .BLANK    (BLANK),
        .LED      (LED)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic rst; logic la; logic lb; logic u; logic l; logic r; logic d; logic t1; logic t2;
    } in_t;

    typedef struct {
        in_t         in;
        int          rep;
        int          hold;
        logic [15:0] bcd;
        logic        chk_bcd;
        logic        led;
        logic        blank;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, display value follows a settled count.
    int          m_count = 0;
    int          m_age = 0;
    logic        m_ph = 1'b0;
    logic        m_led = 1'b1;
    logic [15:0] m_bcd = 16'h0000;

    // X reset, A/B loads, u/l/r/d buttons, 1/2 ticks.
    function automatic in_t ev(input string s);
        in_t x = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "X": x.rst = 1'b1;
                "A": x.la  = 1'b1;
                "B": x.lb  = 1'b1;
                "u": x.u   = 1'b1;
                "l": x.l   = 1'b1;
                "r": x.r   = 1'b1;
                "d": x.d   = 1'b1;
                "1": x.t1  = 1'b1;
                "2": x.t2  = 1'b1;
                default: ;
            endcase
        end
        return x;
    endfunction

    function automatic vec_t mkv(input string s, input int rep, input int hold,
                                 input logic [15:0] bcd, input logic chk,
                                 input logic led, input logic blank);
        vec_t v;
        v.in = ev(s); v.rep = rep; v.hold = hold;
        v.bcd = bcd; v.chk_bcd = chk; v.led = led; v.blank = blank;
        return v;
    endfunction

    function automatic int mode_of(input int c);
        if (c == 0) return 0;
        if (c < 200) return 1;
        return 2;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void model_step(input in_t x);
        int nxt, s, add;
        logic ld;
        if (x.rst) begin
            m_count = 0; m_age = 0; m_ph = 1'b0; m_led = 1'b1; m_bcd = 16'h0000;
            return;
        end
        ld = x.la | x.lb;
        if (x.la) nxt = 10;
        else if (x.lb) nxt = 205;
        else begin
            add = x.u ? 10 : x.l ? 180 : x.r ? 200 : x.d ? 550 : 0;
            s = m_count + add;
            if (s > 9999) s = 9999;
            nxt = (x.t1 && s > 0) ? s - 1 : s;
        end
        if (mode_of(nxt) != mode_of(m_count) || mode_of(nxt) == 2) m_ph = 1'b0;
        else if (!ld) m_ph = m_ph ^ ((mode_of(nxt) == 0) ? x.t2 : x.t1);
        m_led = (nxt == 0);
        if (nxt != m_count) m_age = 0;
        else if (m_age < 100) m_age++;
        if (m_age == 15) m_bcd = to_bcd(nxt);
        m_count = nxt;
    endfunction

    task automatic apply(input in_t x);
        RESET = x.rst; LOAD_A = x.la; LOAD_B = x.lb;
        BTN_U = x.u; BTN_L = x.l; BTN_R = x.r; BTN_D = x.d;
        TICK_1HZ = x.t1; TICK_2HZ = x.t2;
        model_step(x);
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t        tbl[$];
    logic [7:0]  seqa_exp;
    logic        prev_blank;
    in_t         x;

    initial begin
        tbl.push_back(mkv("X",    1,  16, 16'h0000, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mkv("u",    1,  16, 16'h0010, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("u",    1,  16, 16'h0020, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("u",    1,  16, 16'h0030, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("1",    1,  16, 16'h0029, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mkv("2",    1,  16, 16'h0029, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mkv("1",    1,  16, 16'h0028, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("B",    1,  16, 16'h0205, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("l",    1,  16, 16'h0385, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("d1",   1,  16, 16'h0934, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("Ar1",  1,  16, 16'h0010, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("1",    1,  16, 16'h0009, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mkv("ud",   1,  16, 16'h0019, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mkv("r",    1,  16, 16'h0219, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("X",    1,   0, 16'h0000, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mkv("d",   18,  16, 16'h9900, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("d",    1,  16, 16'h9999, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("d1",   1,  16, 16'h9998, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("A",    1,  16, 16'h0010, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mkv("1",    9,  16, 16'h0001, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mkv("1",    1,  16, 16'h0000, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mkv("2",    1,   4, 16'h0000, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mkv("1",    3,  16, 16'h0000, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mkv("2",    1,   0, 16'h0000, 1'b0, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].rep; k++) apply(tbl[i].in);
            for (int k = 0; k < tbl[i].hold; k++) apply('0);
            if (tbl[i].chk_bcd) check($sformatf("row%0d_bcd", i), 32'(BCD), 32'(tbl[i].bcd));
            check($sformatf("row%0d_led", i), 32'(LED), 32'(tbl[i].led));
            check($sformatf("row%0d_blank", i), 32'(BLANK), 32'(tbl[i].blank));
        end

        // Slow blink entry: 205 down to 197 with half-second ticks in between.
        seqa_exp = 8'b0100_0000;
        apply(ev("B"));
        check("seqA_load_blank", 32'(BLANK), 32'd0);
        prev_blank = 1'b0;
        for (int k = 0; k < 8; k++) begin
            apply(ev("2"));
            check($sformatf("seqA_half%0d_blank", k), 32'(BLANK), 32'(prev_blank));
            apply('0);
            apply('0);
            apply(ev("12"));
            check($sformatf("seqA_tick%0d_blank", k), 32'(BLANK), 32'(seqa_exp[k]));
            prev_blank = seqa_exp[k];
        end
        for (int k = 0; k < 16; k++) apply('0);
        check("seqA_bcd", 32'(BCD), 32'h0197);
        check("seqA_led", 32'(LED), 32'd0);

        // Second button mid-conversion: intermediate value never shown, exact latency.
        apply(ev("X"));
        for (int k = 0; k < 3; k++) apply('0);
        apply(ev("u"));
        check("seqB_led", 32'(LED), 32'd0);
        for (int k = 0; k < 4; k++) begin
            apply('0);
            check($sformatf("seqB_pre%0d_bcd", k), 32'(BCD), 32'h0000);
        end
        apply(ev("r"));
        for (int k = 1; k <= 15; k++) begin
            apply('0);
            check($sformatf("seqB_lat%0d_bcd", k), 32'(BCD), (k == 15) ? 32'h0210 : 32'h0000);
        end

        // Reset landing mid-conversion.
        apply(ev("u"));
        for (int k = 0; k < 4; k++) apply('0);
        apply(ev("r"));
        for (int k = 0; k < 5; k++) apply('0);
        apply(ev("X"));
        check("seqC_bcd", 32'(BCD), 32'h0000);
        check("seqC_led", 32'(LED), 32'd1);
        check("seqC_blank", 32'(BLANK), 32'd0);
        for (int k = 0; k < 20; k++) apply('0);
        check("seqC_settle_bcd", 32'(BCD), 32'h0000);

        // Randomized traffic, alternating button-heavy and draining windows.
        apply(ev("X"));
        for (int w = 0; w < 8; w++) begin
            for (int c = 0; c < 500; c++) begin
                x = '0;
                x.rst = ($urandom_range(0, 499) == 0);
                x.la  = ($urandom_range(0, 149) == 0);
                x.lb  = ($urandom_range(0, 149) == 0);
                x.t2  = ($urandom_range(0, 2) == 0);
                if (w % 2 == 0) begin
                    x.u  = ($urandom_range(0, 29) == 0);
                    x.l  = ($urandom_range(0, 29) == 0);
                    x.r  = ($urandom_range(0, 29) == 0);
                    x.d  = ($urandom_range(0, 29) == 0);
                    x.t1 = ($urandom_range(0, 7) == 0);
                end else begin
                    x.u  = ($urandom_range(0, 49) == 0);
                    x.t1 = ($urandom_range(0, 1) == 0);
                end
                apply(x);
                check("rnd_bcd", 32'(BCD), 32'(m_bcd));
                check("rnd_led", 32'(LED), 32'(m_led));
                check("rnd_blank", 32'(BLANK), 32'(m_ph));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
